// File: rtl/writeback_commit_pkg.sv
// Shared types and constants for the writeback/commit stage.
package writeback_commit_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TRAP = 1'b1
  } state_t;

  localparam logic [3:0] INSN_ADDR_MISALIGNED = 4'd0;
  localparam logic [6:0] OP_JALR              = 7'b1100111;

  // Jump targets ignore bit 0, as for JALR.
  function automatic logic [XLEN-1:0] clear_lsb(input logic [XLEN-1:0] v);
    return {v[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/writeback_commit_gpr_file.sv
// 32x32 register file: one write port, two async read ports with write bypass, x0 reads zero.
module writeback_commit_gpr_file
  import writeback_commit_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [REG_IDX_W-1:0] waddr,
  input  logic [XLEN-1:0]      wdata,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val
);

  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rs1_val = (rs1_idx == '0)                ? '0    :
                   (we && (waddr == rs1_idx))      ? wdata : regs[rs1_idx];
  assign rs2_val = (rs2_idx == '0)                ? '0    :
                   (we && (waddr == rs2_idx))      ? wdata : regs[rs2_idx];

endmodule

// File: rtl/writeback_commit.sv
// Commit stage: owns the architectural PC, GPR file and retire counter; traps on misaligned jump targets.
module writeback_commit
  import writeback_commit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic                 reg_pc_w_op,
  input  logic [XLEN-1:0]      reg_pc_w_val,
  input  logic                 reg_w_op,
  input  logic [REG_IDX_W-1:0] reg_w_reg_idx,
  input  logic [XLEN-1:0]      reg_w_reg_val,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  output logic [XLEN-1:0]      rs1_val,
  output logic [XLEN-1:0]      rs2_val,
  output logic [XLEN-1:0]      pc_val,
  output logic                 trap,
  output logic [XLEN-1:0]      trap_tval,
  input  logic                 trap_ack,
  output logic [XLEN-1:0]      retire_cnt
);

  state_t          state;
  logic            fire;
  logic            misaligned;
  logic            commit;
  logic [XLEN-1:0] tgt;

  // wb_ready is only high in RUN, so fire implies RUN.
  assign fire       = wb_valid && wb_ready;
  assign tgt        = clear_lsb(reg_pc_w_val);
  assign misaligned = fire && reg_pc_w_op && tgt[1];
  assign commit     = fire && !misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      pc_val     <= RESET_PC;
      trap       <= 1'b0;
      trap_tval  <= '0;
      retire_cnt <= '0;
      wb_ready   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          wb_ready <= 1'b1;
          if (misaligned) begin
            state     <= ST_TRAP;
            trap      <= 1'b1;
            trap_tval <= tgt;
            wb_ready  <= 1'b0;
          end else if (commit) begin
            pc_val     <= reg_pc_w_op ? tgt : pc_val + 32'd4;
            retire_cnt <= retire_cnt + 32'd1;
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            state    <= ST_RUN;
            pc_val   <= TRAP_VEC;
            trap     <= 1'b0;
            wb_ready <= 1'b1;
          end
        end
      endcase
    end
  end

  writeback_commit_gpr_file u_gpr_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (commit && reg_w_op),
    .waddr   (reg_w_reg_idx),
    .wdata   (reg_w_reg_val),
    .rs1_idx (rs1_idx),
    .rs2_idx (rs2_idx),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val)
  );

endmodule

// File: tb/tb_writeback_commit.sv
// Directed bench for writeback_commit with a reference model and an expected-state scoreboard.
module tb_writeback_commit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wb_valid, wb_ready;
  logic        reg_pc_w_op;
  logic [31:0] reg_pc_w_val;
  logic        reg_w_op;
  logic [4:0]  reg_w_reg_idx;
  logic [31:0] reg_w_reg_val;
  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rs1_val, rs2_val, pc_val, trap_tval, retire_cnt;
  logic        trap, trap_ack;

  always #5 clk = ~clk;

  writeback_commit #(.RESET_PC(RESET_PC), .TRAP_VEC(TRAP_VEC)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .reg_pc_w_op(reg_pc_w_op), .reg_pc_w_val(reg_pc_w_val),
    .reg_w_op(reg_w_op), .reg_w_reg_idx(reg_w_reg_idx), .reg_w_reg_val(reg_w_reg_val),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .pc_val(pc_val), .trap(trap), .trap_tval(trap_tval), .trap_ack(trap_ack),
    .retire_cnt(retire_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [31:0] tval;
    logic        trap;
    logic        ready;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] m_pc, m_cnt, m_tval;
  logic [31:0] m_regs [32];
  logic        m_trap, m_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = RESET_PC; m_cnt = '0; m_tval = '0; m_trap = 1'b0; m_ready = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] idx, input logic wcommit);
    if (idx == 5'd0) return 32'd0;
    if (wcommit && reg_w_op && (reg_w_reg_idx == idx)) return reg_w_reg_val;
    return m_regs[idx];
  endfunction

  // Check same-cycle reads, advance the model, then compare registered state after the edge.
  task automatic step();
    logic        f, mis;
    logic [31:0] t;
    exp_t        e;
    #1;
    f   = wb_valid && m_ready && !m_trap;
    t   = reg_pc_w_val & 32'hFFFF_FFFE;
    mis = f && reg_pc_w_op && t[1];
    check("rs1_val", rs1_val, exp_read(rs1_idx, f && !mis));
    check("rs2_val", rs2_val, exp_read(rs2_idx, f && !mis));
    if (m_trap) begin
      if (trap_ack) begin m_pc = TRAP_VEC; m_trap = 1'b0; end
    end else if (mis) begin
      m_trap = 1'b1; m_tval = t;
    end else if (f) begin
      if (reg_w_op && reg_w_reg_idx != 5'd0) m_regs[reg_w_reg_idx] = reg_w_reg_val;
      m_pc  = reg_pc_w_op ? t : m_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end
    m_ready = !m_trap;
    e.pc = m_pc; e.cnt = m_cnt; e.tval = m_tval; e.trap = m_trap; e.ready = m_ready;
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    check("pc_val", pc_val, e.pc);
    check("retire_cnt", retire_cnt, e.cnt);
    check("trap", {31'd0, trap}, {31'd0, e.trap});
    check("trap_tval", trap_tval, e.tval);
    check("wb_ready", {31'd0, wb_ready}, {31'd0, e.ready});
  endtask

  task automatic req(input logic v, input logic pco, input logic [31:0] pcv,
                     input logic wo, input logic [4:0] wi, input logic [31:0] wv,
                     input logic [4:0] r1, input logic [4:0] r2);
    @(negedge clk);
    wb_valid = v; reg_pc_w_op = pco; reg_pc_w_val = pcv;
    reg_w_op = wo; reg_w_reg_idx = wi; reg_w_reg_val = wv;
    rs1_idx = r1; rs2_idx = r2;
    step();
  endtask

  initial begin
    wb_valid = 0; reg_pc_w_op = 0; reg_pc_w_val = '0; reg_w_op = 0;
    reg_w_reg_idx = '0; reg_w_reg_val = '0; rs1_idx = '0; rs2_idx = '0; trap_ack = 0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check("reset_wb_ready", {31'd0, wb_ready}, 32'd0);
    check("reset_pc", pc_val, RESET_PC);
    check("reset_trap", {31'd0, trap}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    repeat (5) req(0, 0, '0, 0, '0, '0, '0, '0);
    for (int i = 0; i < 32; i++) req(0, 0, '0, 0, '0, '0, 5'(i), 5'(31 - i));

    // Sequential fire with GPR write and same-cycle bypass.
    req(1, 0, '0, 1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd0);
    req(0, 0, '0, 0, '0, '0, 5'd5, 5'd0);

    // Jump with link; target bit 0 cleared.
    req(1, 1, 32'h0000_1235, 1, 5'd1, 32'h8, 5'd1, 5'd5);
    req(0, 0, '0, 0, '0, '0, 5'd1, 5'd5);

    // Misaligned target: trap, no GPR write, no bypass.
    req(1, 1, 32'h0000_1002, 1, 5'd2, 32'h55, 5'd2, 5'd1);
    repeat (3) req(1, 0, '0, 1, 5'd3, 32'h77, 5'd3, 5'd2);
    trap_ack = 1'b1;
    req(0, 0, '0, 0, '0, '0, 5'd2, 5'd3);
    trap_ack = 1'b0;
    req(0, 0, '0, 0, '0, '0, 5'd2, 5'd3);

    // Writes to x0 are dropped.
    req(1, 0, '0, 1, 5'd0, 32'h1, 5'd0, 5'd0);
    req(0, 0, '0, 0, '0, '0, 5'd0, 5'd1);

    // PC wraps mod 2^32.
    req(1, 1, 32'hFFFF_FFFC, 0, '0, '0, 5'd1, 5'd5);
    req(1, 0, '0, 0, '0, '0, 5'd1, 5'd5);

    // Async reset while trapped.
    req(1, 1, 32'h0000_0006, 1, 5'd4, 32'h99, 5'd1, 5'd5);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("rst_trap", {31'd0, trap}, 32'd0);
    check("rst_pc", pc_val, RESET_PC);
    check("rst_wb_ready", {31'd0, wb_ready}, 32'd0);
    check("rst_retire_cnt", retire_cnt, 32'd0);
    check("rst_x1", rs1_val, 32'd0);
    check("rst_x5", rs2_val, 32'd0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    req(0, 0, '0, 0, '0, '0, 5'd1, 5'd5);
    req(1, 0, '0, 1, 5'd7, 32'h1234_5678, 5'd7, 5'd5);
    req(0, 0, '0, 0, '0, '0, 5'd7, 5'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_commit.md
Name: writeback_commit

Overview:
Commit stage at the consuming end of the execute-unit write-request interface. It takes one request per handshake: an optional PC write (op/val) and an optional GPR write (op/idx/val). It owns the architectural PC and the 32x32 GPR file, and raises an instruction-address-misaligned trap for bad PC targets. It also provides bypassed GPR read ports to decode/execute and a retired-instruction counter.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when a trap is acknowledged

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
wb_valid  in  1  execute presents a request this cycle
wb_ready  out  1  commit can accept; transfer ("fire") when wb_valid && wb_ready
reg_pc_w_op  in  1  request writes PC
reg_pc_w_val  in  32  requested PC target
reg_w_op  in  1  request writes a GPR
reg_w_reg_idx  in  5  destination GPR index
reg_w_reg_val  in  32  GPR write data
rs1_idx  in  5  read port 1 index
rs2_idx  in  5  read port 2 index
rs1_val  out  32  read port 1 data, combinational
rs2_val  out  32  read port 2 data, combinational
pc_val  out  32  current architectural PC, registered
trap  out  1  misaligned-target trap pending
trap_tval  out  32  offending target (after bit-0 clear)
trap_ack  in  1  trap handler acknowledges
retire_cnt  out  32  retired-request count, wraps

Behaviour:
- Reset (async, rst_n=0): pc_val=RESET_PC, state=RUN, trap=0, trap_tval=0, retire_cnt=0, all GPRs=0. wb_ready=0 while rst_n=0. A reset asserted mid-trap returns to RUN with the trap cleared.
- States: RUN, TRAP. wb_ready=1 in RUN and 0 in TRAP, registered from state.
- RUN, fire, reg_pc_w_op=1:
  - tgt = reg_pc_w_val & ~32'h1.
  - If tgt[1]=1: next state TRAP, trap=1, trap_tval=tgt. PC unchanged, no GPR write, retire_cnt unchanged.
  - Otherwise: pc_val<=tgt.
- RUN, fire, reg_pc_w_op=0: pc_val<=pc_val+4, wrapping mod 2^32.
- GPR write on non-trapping fire: if reg_w_op=1 and idx!=0, regs[idx]<=reg_w_reg_val. A write to idx 0 is dropped, so x0 always reads 0.
- retire_cnt increments by 1 on every non-trapping fire and wraps from FFFF_FFFF to 0.
- No fire: PC, GPRs and retire_cnt hold. Request fields are ignored when wb_valid=0.
- TRAP state:
  - trap and trap_tval hold until trap_ack=1 is sampled.
  - Then pc_val<=TRAP_VEC, trap<=0, state<=RUN; wb_ready is 1 from the next cycle.
  - wb_valid is ignored while in TRAP.
- Read ports: rsN_val = 0 if rsN_idx=0.
  - Else, if a non-trapping fire this cycle has reg_w_op=1 and reg_w_reg_idx==rsN_idx, return reg_w_reg_val (bypass).
  - Else return regs[rsN_idx].
  - The bypass decision depends on the trap check of the same cycle.
- Latency: state updates are visible one cycle after fire; read bypass is zero-cycle.

Decomposition:
- Shared package:
  - XLEN=32, REG_IDX_W=5
  - state encoding for RUN/TRAP
  - cause constant INSN_ADDR_MISALIGNED=0
  - OP_JALR=7'b1100111
- Sub-module gpr_file: 32x32, 1 write port, 2 async read ports, x0 hardwired zero, internal bypass. It keeps the FSM/PC logic separate from storage.

Test Plan:
- Reset then idle 5 cycles -> pc_val=0, retire_cnt=0, wb_ready=1 after release, rs1_val=0 for all indices.
- Fire with pc_w_op=0, reg_w_op=1, idx=5, val=32'hDEAD_BEEF; same-cycle rs1_idx=5 -> rs1_val=DEAD_BEEF (bypass), next cycle pc_val=4, retire_cnt=1, regs[5] reads DEAD_BEEF.
- JALR-style fire: pc_w_op=1, val=32'h0000_1235, reg_w_op=1, idx=1, val=32'h8 -> pc_val=32'h1234, x1=8.
- Misaligned fire: pc_w_op=1, val=32'h0000_1002, reg_w_op=1, idx=2 -> trap=1, trap_tval=32'h1002, x2 unchanged, PC unchanged, wb_ready=0. Hold trap_ack=0 for 3 cycles -> trap stays 1. Pulse trap_ack -> pc_val=32'h100, trap=0, wb_ready=1.
- Write idx=0 with val=32'h1 -> rs1_idx=0 reads 0 same cycle and after. Also pc_val=FFFF_FFFC plus a sequential fire -> pc_val=0.
- Assert rst_n=0 asynchronously while in TRAP -> trap=0, pc_val=RESET_PC immediately, GPRs zeroed, RUN after release.
